// File: rtl/light_pkg.sv
// light_pkg: shared mode encodings, default sizes and pattern type for the light sequencer
//   MODE_STOP / MODE_FWD / MODE_REV / MODE_ONESHOT : 2-bit mode encodings
//   DEF_NUM_LINES / DEF_NUM_STEPS                  : default table geometry
//   pattern_t                                      : one step of light bits at the default width
package light_pkg;

    typedef enum logic [1:0] {
        MODE_STOP    = 2'b00,
        MODE_FWD     = 2'b01,
        MODE_REV     = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    localparam int DEF_NUM_LINES = 8;
    localparam int DEF_NUM_STEPS = 60;

    typedef logic [DEF_NUM_LINES-1:0] pattern_t;

endpackage

// File: rtl/light_step_counter.sv
// light_step_counter: step index register with forward/reverse/one-shot walking, wrap and done flags
//   clk, rst_n          : clock, async active-low reset
//   en, tick, restart   : freeze gate, step strobe, reload of the start step
//   mode                : STOP / FWD / REV / ONESHOT
//   step                : current table index
//   wrap                : one-cycle pulse after a loop wrap
//   done                : sticky one-shot completion flag
module light_step_counter
    import light_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int SEL_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic             restart,
    input  logic [1:0]       mode,
    output logic [SEL_W-1:0] step,
    output logic             wrap,
    output logic             done
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_STEPS - 1);

    logic [SEL_W-1:0] step_nxt;
    logic             wrap_nxt;
    logic             done_nxt;
    logic             adv;
    logic             at_last;
    logic             at_first;

    assign at_last  = (step == LAST);
    assign at_first = (step == '0);
    assign adv = en & tick & ~restart & (mode != MODE_STOP) & ~((mode == MODE_ONESHOT) & done);

    // Wrap uses explicit compares so a table shorter than 2**SEL_W never overflows into unused indices.
    always_comb begin
        step_nxt = step;
        wrap_nxt = 1'b0;
        done_nxt = done;
        if (restart) begin
            step_nxt = (mode == MODE_REV) ? LAST : '0;
            done_nxt = 1'b0;
        end else if (adv) begin
            if (mode == MODE_FWD) begin
                step_nxt = at_last ? '0 : step + 1'b1;
                wrap_nxt = at_last;
            end else if (mode == MODE_REV) begin
                step_nxt = at_first ? LAST : step - 1'b1;
                wrap_nxt = at_first;
            end else begin
                // One-shot entered while already parked on the last step simply completes there.
                step_nxt = at_last ? step : step + 1'b1;
                done_nxt = at_last | (step + 1'b1 == LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            wrap <= 1'b0;
            done <= 1'b0;
        end else begin
            step <= step_nxt;
            wrap <= wrap_nxt;
            done <= done_nxt;
        end
    end

endmodule

// File: rtl/light_pattern_sequencer.sv
// light_pattern_sequencer: programmable pattern table walked by a step counter, driving registered light lines
//   clk, rst_n                          : clock, async active-low reset
//   en, mode, tick, restart             : sequencing controls
//   wr_valid, wr_ready, wr_addr, wr_data: pattern write port (valid/ready)
//   lines                               : registered light outputs
//   step, wrap, done                    : counter status
//   wr_err                              : pulse after an accepted out-of-range write
module light_pattern_sequencer
    import light_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int SEL_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 tick,
    input  logic                 restart,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [SEL_W-1:0]     wr_addr,
    input  logic [NUM_LINES-1:0] wr_data,
    output logic [NUM_LINES-1:0] lines,
    output logic [SEL_W-1:0]     step,
    output logic                 wrap,
    output logic                 done,
    output logic                 wr_err
);

    logic [NUM_LINES-1:0] pat_mem [NUM_STEPS];
    logic                 accept;
    logic                 in_range;

    assign accept   = wr_valid & wr_ready;
    assign in_range = 32'(wr_addr) < NUM_STEPS;

    light_step_counter #(
        .NUM_STEPS (NUM_STEPS),
        .SEL_W     (SEL_W)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .tick    (tick),
        .restart (restart),
        .mode    (mode),
        .step    (step),
        .wrap    (wrap),
        .done    (done)
    );

    // Per-entry address match keeps out-of-range addresses from ever indexing the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) pat_mem[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STEPS; i++)
                if (accept && wr_addr == SEL_W'(i)) pat_mem[i] <= wr_data;
        end
    end

    // Lines read the table through the step register, so a same-edge write shows one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines    <= '0;
            wr_ready <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            lines    <= en ? pat_mem[step] : '0;
            wr_ready <= ~restart;
            wr_err   <= accept & ~in_range;
        end
    end

endmodule

// File: tb/tb_light_pattern_sequencer.sv
// tb_light_pattern_sequencer: directed self-checking bench for light_pattern_sequencer
module tb_light_pattern_sequencer;
    import light_pkg::*;

    localparam int NL = 8;
    localparam int NS = 60;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic          tick;
    logic          restart;
    logic          wr_valid;
    logic          wr_ready;
    logic [SW-1:0] wr_addr;
    pattern_t      wr_data;
    pattern_t      lines;
    logic [SW-1:0] step;
    logic          wrap;
    logic          done;
    logic          wr_err;

    int checks = 0;
    int errors = 0;

    light_pattern_sequencer #(
        .NUM_LINES (NL),
        .NUM_STEPS (NS),
        .SEL_W     (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .tick     (tick),
        .restart  (restart),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lines    (lines),
        .step     (step),
        .wrap     (wrap),
        .done     (done),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart(input logic [1:0] m);
        mode    = m;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = MODE_STOP; tick = 1'b0; restart = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        cyc();
        cyc();
        checks++;
        if (step !== 6'd0 || lines !== 8'h00 || wrap !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: step=%0d lines=%h wrap=%b done=%b wr_err=%b wr_ready=%b, want 0 for all", step, lines, wrap, done, wr_err, wr_ready);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: wr_ready=%b want 1", wr_ready);
        end
    endtask

    task automatic test_load();
        for (int a = 0; a < NS; a++) begin
            wr_valid = 1'b1;
            wr_addr  = SW'(a);
            wr_data  = NL'(a);
            cyc();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_fwd();
        int wraps = 0;
        en = 1'b1;
        mode = MODE_FWD;
        cyc();
        for (int k = 1; k <= NS; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            wraps += int'(wrap);
            checks++;
            if (step !== SW'(k % NS) || lines !== NL'(k - 1)) begin
                errors++;
                $display("FAIL fwd_step k=%0d: step=%0d lines=%h want step=%0d lines=%h", k, step, lines, k % NS, k - 1);
            end
            cyc();
            wraps += int'(wrap);
            checks++;
            if (lines !== NL'(k % NS)) begin
                errors++;
                $display("FAIL fwd_lines k=%0d: lines=%h want %h", k, lines, k % NS);
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL fwd_wrap_count: saw %0d wrap cycles want 1", wraps);
        end
    endtask

    task automatic test_rev();
        int wraps = 0;
        do_restart(MODE_REV);
        checks++;
        if (step !== 6'd59 || wrap !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rev_restart: step=%0d wrap=%b done=%b wr_ready=%b want 59 0 0 0", step, wrap, done, wr_ready);
        end
        cyc();
        checks++;
        if (wr_ready !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL rev_ready_back: wr_ready=%b wrap=%b want 1 0", wr_ready, wrap);
        end
        for (int k = 1; k <= NS; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            wraps += int'(wrap);
            checks++;
            if (step !== SW'((59 - k + NS) % NS) || wrap !== (k == NS)) begin
                errors++;
                $display("FAIL rev_step k=%0d: step=%0d wrap=%b want step=%0d wrap=%b", k, step, wrap, (59 - k + NS) % NS, k == NS);
            end
        end
        checks++;
        if (wraps != 1 || step !== 6'd59) begin
            errors++;
            $display("FAIL rev_end: wraps=%0d step=%0d want 1 59", wraps, step);
        end
    endtask

    task automatic test_oneshot();
        do_restart(MODE_ONESHOT);
        for (int k = 1; k <= 70; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            checks++;
            if (step !== SW'(k < 59 ? k : 59) || done !== (k >= 59) || wrap !== 1'b0) begin
                errors++;
                $display("FAIL oneshot k=%0d: step=%0d done=%b wrap=%b want step=%0d done=%b wrap=0", k, step, done, wrap, k < 59 ? k : 59, k >= 59);
            end
        end
        do_restart(MODE_ONESHOT);
        checks++;
        if (step !== 6'd0 || done !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_restart: step=%0d done=%b wr_ready=%b want 0 0 0", step, done, wr_ready);
        end
        cyc();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_ready_back: wr_ready=%b want 1", wr_ready);
        end
    endtask

    task automatic test_write_err();
        mode = MODE_STOP;
        wr_valid = 1'b1; wr_addr = 6'd60; wr_data = 8'hFF;
        cyc();
        wr_valid = 1'b0;
        checks++;
        if (wr_err !== 1'b1 || lines !== 8'h00) begin
            errors++;
            $display("FAIL wr_err_pulse: wr_err=%b lines=%h want 1 00", wr_err, lines);
        end
        cyc();
        checks++;
        if (wr_err !== 1'b0 || lines !== 8'h00) begin
            errors++;
            $display("FAIL wr_err_clear: wr_err=%b lines=%h want 0 00", wr_err, lines);
        end
    endtask

    task automatic test_collision();
        wr_valid = 1'b1; wr_addr = step; wr_data = 8'hA5;
        cyc();
        wr_valid = 1'b0;
        checks++;
        if (lines !== 8'h00) begin
            errors++;
            $display("FAIL collision_old: lines=%h want 00", lines);
        end
        cyc();
        checks++;
        if (lines !== 8'hA5) begin
            errors++;
            $display("FAIL collision_new: lines=%h want a5", lines);
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        mode = MODE_FWD;
        for (int k = 0; k < 5; k++) begin
            tick = 1'b1;
            cyc();
            checks++;
            if (step !== 6'd0 || lines !== 8'h00) begin
                errors++;
                $display("FAIL en_off k=%0d: step=%0d lines=%h want 0 00", k, step, lines);
            end
        end
        tick = 1'b0;
        en = 1'b1;
        cyc();
        checks++;
        if (lines !== 8'hA5) begin
            errors++;
            $display("FAIL en_on: lines=%h want a5", lines);
        end
    endtask

    task automatic test_tick_write();
        tick = 1'b1;
        wr_valid = 1'b1; wr_addr = 6'd1; wr_data = 8'h5A;
        cyc();
        tick = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (step !== 6'd1 || lines !== 8'hA5) begin
            errors++;
            $display("FAIL tick_write_edge: step=%0d lines=%h want 1 a5", step, lines);
        end
        cyc();
        checks++;
        if (lines !== 8'h5A) begin
            errors++;
            $display("FAIL tick_write_lines: lines=%h want 5a", lines);
        end
    endtask

    task automatic test_reset_mid();
        do_restart(MODE_FWD);
        for (int k = 0; k < 30; k++) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
        cyc();
        checks++;
        if (step !== 6'd30 || lines !== 8'h1E || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_before: step=%0d lines=%h wr_ready=%b want 30 1e 1", step, lines, wr_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (step !== 6'd0 || lines !== 8'h00 || done !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: step=%0d lines=%h done=%b wr_ready=%b want 0 00 0 0", step, lines, done, wr_ready);
        end
        rst_n = 1'b1;
        cyc();
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (lines !== 8'h00) begin
                errors++;
                $display("FAIL mid_table entry=%0d: lines=%h want 00", k, lines);
            end
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
        checks++;
        if (step !== 6'd0) begin
            errors++;
            $display("FAIL mid_walk_end: step=%0d want 0", step);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fwd();
        test_rev();
        test_oneshot();
        test_write_err();
        test_collision();
        test_enable();
        test_tick_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_pattern_sequencer.md
Name: light_pattern_sequencer

Overview:
Parametrised, programmable successor to the per-line fixed light decoders. It holds a writable pattern table of NUM_STEPS entries, each NUM_LINES bits wide. An internal step counter walks the table on a tick strobe, and the block drives all light lines from one registered output. It supports forward loop, reverse loop and one-shot modes, plus runtime pattern load over a valid/ready write port.

Parameters:
NUM_LINES, 8, number of light lines driven (one bit per line per step)
NUM_STEPS, 60, pattern table depth; legal range 2..2**SEL_W
SEL_W, 6, step index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  output enable; 0 forces lines to 0 and freezes the step counter
mode  in  2  00 STOP, 01 FWD loop, 10 REV loop, 11 ONESHOT forward
tick  in  1  single-cycle step strobe from the rate divider
restart  in  1  reload the start step and clear done
wr_valid  in  1  pattern write request
wr_ready  out  1  write port able to accept
wr_addr  in  SEL_W  table entry to write
wr_data  in  NUM_LINES  pattern bits for that entry
lines  out  NUM_LINES  registered light outputs
step  out  SEL_W  current step index
wrap  out  1  one-cycle pulse when the counter wraps
done  out  1  ONESHOT reached the last step (sticky)
wr_err  out  1  one-cycle pulse on an accepted write with out-of-range address

Behaviour:
- Reset (async, rst_n=0): step=0, lines=0, wrap=0, done=0, wr_err=0, wr_ready=0, all table entries=0.
- wr_ready is registered. It rises on the first clk edge after rst_n deasserts. It is low for exactly the one cycle following a restart cycle; otherwise it is 1.
- Write accept = wr_valid & wr_ready.
  - wr_addr < NUM_STEPS: the entry is updated at that edge.
  - wr_addr >= NUM_STEPS: the table is unchanged and wr_err pulses the next cycle.
- Advance condition = en & tick & ~restart & mode!=STOP & ~(mode==ONESHOT & done).
- FWD: step+1. At NUM_STEPS-1, step goes to 0 and wrap pulses in the cycle after the edge.
- REV: step-1. At 0, step goes to NUM_STEPS-1 and wrap pulses.
- ONESHOT: step+1 until NUM_STEPS-1. The advance that lands on NUM_STEPS-1 sets done. Further ticks are ignored; there is no wrap pulse.
- restart (priority over tick): step goes to NUM_STEPS-1 if mode==REV, else 0. done is cleared and wrap is not pulsed. restart is honoured even when en=0.
- A mode change mid-run does not move step; the new direction applies from the next tick. Switching to ONESHOT with done=1 stays frozen until restart.
- lines <= en ? table[step] : 0, evaluated every cycle. Latency: a step change at edge N appears on lines at edge N+1.
- Write/read collision: a write to the entry currently selected by step is visible on lines at edge N+1 after the accept edge N. The old value is shown at N.
- Simultaneous tick and write to the next step: lines shows the new data; the write lands at the same edge as the step change, and lines is sampled one edge later.
- Reset asserted mid-run: all state returns to reset values immediately, including the table; no partial write survives.
- Counter arithmetic is SEL_W-bit. Wrap is by explicit compare against NUM_STEPS-1 and 0, never natural overflow, so that NUM_STEPS < 2**SEL_W works.

Decomposition:
- Shared package light_pkg holds:
  - mode encodings MODE_STOP, MODE_FWD, MODE_REV, MODE_ONESHOT;
  - default NUM_LINES and NUM_STEPS constants;
  - the per-step pattern typedef, sized by NUM_LINES.
- One sub-module, light_step_counter, contains:
  - the step register with its direction, wrap and done logic;
  - inputs en, tick, restart, mode;
  - outputs step, wrap, done.
- The table, write port and output register stay in the top level.

Test Plan:
- Reset then load entries 0..59 with data=addr[7:0]; FWD, en=1, 60 ticks → lines follows 0x00..0x3B one cycle after each step; wrap pulses once when step goes 59→0.
- REV after restart → step=59 with no wrap pulse; 60 ticks → step ends at 59, wrap pulses once on the 0→59 transition.
- ONESHOT from step 0: 70 ticks → step holds at 59, done=1 after the 59th tick, no wrap; restart → step=0, done=0, wr_ready low for one cycle.
- Write addr=60, data=0xFF → wr_err pulses, table unchanged; write addr=step with data=0xA5 while holding (mode=STOP) → lines=0xA5 one cycle after the accept edge, old value on the accept edge.
- en=0 with ticks → step frozen, lines=0x00; en=1 → lines=table[step] next cycle.
- Assert rst_n=0 mid-FWD at step 30 → step, lines, done and wr_ready go to 0 immediately; after release, all entries read 0x00.
